playback_controller: RTL and testbench
======================================

PLAYBACK_CONTROLLER -- requirements
Module: playback_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of DAC channels/chip selects, range 1..8.
REQ-002 SHALL have parameter DEB_CYCLES, default 50000: consecutive stable cycles required to accept a start level change, minimum 2.
REQ-003 SHALL have parameter INIT_TIMEOUT, default 1000000: maximum INIT cycles before fault, minimum 2.
REQ-004 Clk  in  1  sole clock; all state changes occur on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset: 0 resets immediately, independent of Clk.
REQ-006 start  in  1  raw, asynchronous, bouncing pushbutton level.
REQ-007 init_finish  in  1  DAC initialisation done; level-sensitive.
REQ-008 ch_mask  in  NUM_CH  channel enables; sampled only when leaving IDLE.
REQ-009 init  out  1  DAC initialisation request/enable.
REQ-010 CS  out  NUM_CH  per-channel chip select, active-high.
REQ-011 running  out  1  high only in RUN.
REQ-012 fault  out  1  high only in FAULT.

Function
REQ-013 start SHALL pass through a 2-flop synchroniser before any use.
REQ-014 Debounce: counter increments each cycle the synchronised level differs from the debounced level and clears when they match; on reaching DEB_CYCLES the debounced level flips and the counter clears.
REQ-015 A "toggle" event SHALL be a one-cycle pulse in the cycle after the debounced level falls 1->0, i.e. on press-then-release; a press alone SHALL NOT generate an event.
REQ-016 States SHALL be IDLE, INIT, RUN, FAULT.
REQ-017 IDLE: on toggle, latch ch_mask into mask_q; go to FAULT if the latched value is all zero, else to INIT.
REQ-018 INIT: timeout counter increments each cycle from 0; init_finish=1 -> RUN; toggle -> IDLE (abort); counter reaching INIT_TIMEOUT-1 without init_finish -> FAULT.
REQ-019 In INIT, priority SHALL be toggle > init_finish > timeout when they coincide.
REQ-020 RUN: toggle -> IDLE; init_finish deassertion SHALL be ignored.
REQ-021 FAULT: toggle -> IDLE; no other exit.
REQ-022 Outputs SHALL decode combinationally from state and mask_q, with no extra latency.
REQ-023 Output decode: IDLE: init=0, CS=0; INIT: init=1, CS=0; RUN: init=1, CS=mask_q; FAULT: init=0, CS=0, fault=1.
REQ-024 The timeout counter SHALL clear on every INIT entry, SHALL be wide enough for INIT_TIMEOUT-1 (clog2), and SHALL NOT wrap.
REQ-025 mask_q SHALL hold its value outside the IDLE exit, so ch_mask changes during RUN have no effect.
REQ-026 Illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-027 While Reset=0: state=IDLE; init, CS, running and fault=0; mask_q, timeout counter and debounce counter=0; synchroniser flops and debounced level=0.
REQ-028 Reset deassertion mid-operation SHALL resume from IDLE, with no toggle event generated by the first cycles after reset.

Verification (NUM_CH=4, DEB_CYCLES=4, INIT_TIMEOUT=16)
REQ-029 Clean press/release with ch_mask=4'b1011 -> INIT (init=1, CS=0); init_finish=1 at cycle 5 -> RUN, CS=4'b1011, running=1; second press/release -> IDLE, all outputs 0.
REQ-030 start bouncing with runs of 1-3 cycles for 20 cycles, then stable 0 -> no toggle event, remains in IDLE.
REQ-031 Enter INIT, hold init_finish=0 -> FAULT after exactly 16 INIT cycles, fault=1, init=0; press/release -> IDLE.
REQ-032 ch_mask=0 at toggle -> IDLE goes directly to FAULT, with INIT never visited.
REQ-033 Toggle coinciding with init_finish in INIT -> IDLE, not RUN; separately, Reset=0 pulsed asynchronously in RUN -> outputs 0 before the next Clk edge.

Source files
------------

// File: rtl/playback_controller.sv
// Pushbutton-driven DAC playback sequencer: synchronises and debounces the start
// button, then walks IDLE -> INIT -> RUN (or FAULT) and decodes DAC enables/chip selects.
module playback_controller #(
    parameter int NUM_CH       = 4,
    parameter int DEB_CYCLES   = 50000,
    parameter int INIT_TIMEOUT = 1000000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              init_finish,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              init,
    output logic [NUM_CH-1:0] CS,
    output logic              running,
    output logic              fault
);
    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam int TMO_W = $clog2(INIT_TIMEOUT);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(INIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    logic              sync1_q, sync2_q;
    logic              deb_q, deb_d;
    logic              deb_dly_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              toggle;
    state_t            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= start;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // The level must disagree for DEB_CYCLES consecutive cycles before it is accepted.
    always_comb begin
        deb_cnt_d = '0;
        deb_d     = deb_q;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Release edge only: a press alone never produces an event.
    assign toggle = deb_dly_q & ~deb_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            tmo_q   <= tmo_d;
        end
    end

    // Timeout counter is held at zero outside INIT, so every entry starts from 0.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        tmo_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (toggle) begin
                    mask_d  = ch_mask;
                    state_d = (ch_mask == '0) ? S_FAULT : S_INIT;
                end
            end
            S_INIT: begin
                if (toggle) begin
                    state_d = S_IDLE;
                end else if (init_finish) begin
                    state_d = S_RUN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_RUN: begin
                if (toggle) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                if (toggle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        init    = 1'b0;
        CS      = '0;
        running = 1'b0;
        fault   = 1'b0;
        case (state_q)
            S_INIT: init = 1'b1;
            S_RUN: begin
                init    = 1'b1;
                CS      = mask_q;
                running = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_playback_controller.sv
// Bench for playback_controller: directed scenarios plus a randomized run checked
// against a queue-based behavioural model of the button and sequencer.
module tb_playback_controller;
    localparam int NUM_CH = 4;
    localparam int DEB    = 4;
    localparam int TMO    = 16;

    localparam int M_IDLE  = 0;
    localparam int M_INIT  = 1;
    localparam int M_RUN   = 2;
    localparam int M_FAULT = 3;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              start = 1'b0;
    logic              init_finish = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic              init;
    logic [NUM_CH-1:0] CS;
    logic              running;
    logic              fault;

    int n_checks = 0;
    int n_errors = 0;

    playback_controller #(
        .NUM_CH(NUM_CH),
        .DEB_CYCLES(DEB),
        .INIT_TIMEOUT(TMO)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .start(start),
        .init_finish(init_finish),
        .ch_mask(ch_mask),
        .init(init),
        .CS(CS),
        .running(running),
        .fault(fault)
    );

    always #5 Clk = ~Clk;

    // Reference model: raw samples age through a two-deep queue; the accepted level
    // flips once the last DEB synchronised samples all disagree with it.
    bit                rawq[$];
    bit                sq[$];
    bit                m_deb;
    bit                m_fell;
    bit                m_tog;
    bit                m_sync;
    bit                m_all;
    int                m_state;
    int                m_age;
    logic [NUM_CH-1:0] m_mask;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rawq    = '{1'b0, 1'b0};
            sq.delete();
            m_deb   = 1'b0;
            m_fell  = 1'b0;
            m_state = M_IDLE;
            m_age   = 0;
            m_mask  = '0;
        end else begin
            m_tog  = m_fell;
            m_sync = rawq[0];
            void'(rawq.pop_front());
            rawq.push_back(start);
            sq.push_back(m_sync);
            if (sq.size() > DEB) void'(sq.pop_front());
            m_all = (sq.size() == DEB);
            foreach (sq[k]) if (sq[k] == m_deb) m_all = 1'b0;
            m_fell = 1'b0;
            if (m_all) begin
                m_fell = m_deb;
                m_deb  = !m_deb;
                sq.delete();
            end
            case (m_state)
                M_IDLE: if (m_tog) begin
                    m_mask  = ch_mask;
                    m_state = (ch_mask == 0) ? M_FAULT : M_INIT;
                    m_age   = 0;
                end
                M_INIT: begin
                    if (m_tog) m_state = M_IDLE;
                    else if (init_finish) m_state = M_RUN;
                    else begin
                        m_age++;
                        if (m_age >= TMO) m_state = M_FAULT;
                    end
                end
                default: if (m_tog) m_state = M_IDLE;
            endcase
        end
    end

    task automatic press_release(input int hi, input int lo);
        start = 1'b1;
        repeat (hi) @(negedge Clk);
        start = 1'b0;
        repeat (lo) @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if (init !== 1'b0) begin n_errors++; $display("FAIL reset_init: got %b want 0", init); end
        n_checks++;
        if (CS !== 4'b0000) begin n_errors++; $display("FAIL reset_cs: got %b want 0000", CS); end
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL reset_running: got %b want 0", running); end
        n_checks++;
        if (fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_clean();
        ch_mask = 4'b1011;
        press_release(6, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (init) break;
        end
        n_checks++;
        if (init !== 1'b1) begin n_errors++; $display("FAIL clean_init: init got %b want 1", init); end
        n_checks++;
        if (CS !== 4'b0000) begin n_errors++; $display("FAIL clean_init_cs: got %b want 0000", CS); end
        ch_mask = 4'b0110;
        repeat (4) @(negedge Clk);
        init_finish = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (running !== 1'b1) begin n_errors++; $display("FAIL clean_run: running got %b want 1", running); end
        n_checks++;
        if (CS !== 4'b1011) begin n_errors++; $display("FAIL clean_run_cs: got %b want 1011", CS); end
        init_finish = 1'b0;
        ch_mask = 4'b0001;
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({running, init, CS} !== 6'b111011) begin
            n_errors++; $display("FAIL run_hold: {running,init,CS} got %b want 111011", {running, init, CS});
        end
        press_release(6, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (!running) break;
        end
        n_checks++;
        if ({init, CS, running, fault} !== 7'b0) begin
            n_errors++; $display("FAIL clean_idle: outputs got %b want 0000000", {init, CS, running, fault});
        end
    endtask

    task automatic test_bounce();
        bit lvl = 1'b1;
        bit left_idle = 1'b0;
        int t = 0;
        ch_mask = 4'b1111;
        while (t < 20) begin
            int run = $urandom_range(1, 3);
            start = lvl;
            for (int r = 0; r < run && t < 20; r++) begin
                @(negedge Clk);
                t++;
                if (init || fault) left_idle = 1'b1;
            end
            lvl = !lvl;
        end
        start = 1'b0;
        repeat (30) begin
            @(negedge Clk);
            if (init || fault) left_idle = 1'b1;
        end
        n_checks++;
        if (left_idle !== 1'b0) begin n_errors++; $display("FAIL bounce_idle: left IDLE got %b want 0", left_idle); end
    endtask

    task automatic test_timeout();
        int init_cnt = 0;
        ch_mask = 4'b0011;
        init_finish = 1'b0;
        press_release(6, 0);
        for (int k = 0; k < 60; k++) begin
            @(negedge Clk);
            if (fault) break;
            if (init) init_cnt++;
        end
        n_checks++;
        if (fault !== 1'b1) begin n_errors++; $display("FAIL timeout_fault: fault got %b want 1", fault); end
        n_checks++;
        if (init_cnt != TMO) begin n_errors++; $display("FAIL timeout_len: INIT cycles got %0d want %0d", init_cnt, TMO); end
        n_checks++;
        if (init !== 1'b0) begin n_errors++; $display("FAIL timeout_init: init got %b want 0", init); end
        press_release(6, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (!fault) break;
        end
        n_checks++;
        if ({init, running, fault} !== 3'b000) begin
            n_errors++; $display("FAIL fault_exit: {init,running,fault} got %b want 000", {init, running, fault});
        end
    endtask

    task automatic test_zero_mask();
        bit saw_init = 1'b0;
        ch_mask = 4'b0000;
        press_release(6, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (init) saw_init = 1'b1;
            if (fault) break;
        end
        n_checks++;
        if (fault !== 1'b1) begin n_errors++; $display("FAIL zero_mask_fault: fault got %b want 1", fault); end
        n_checks++;
        if (saw_init !== 1'b0) begin n_errors++; $display("FAIL zero_mask_noinit: saw init got %b want 0", saw_init); end
        ch_mask = 4'b1111;
        press_release(6, 0);
        repeat (12) @(negedge Clk);
    endtask

    task automatic test_abort_coincide();
        bit hit = 1'b0;
        ch_mask = 4'b0101;
        init_finish = 1'b0;
        press_release(6, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (init) break;
        end
        press_release(5, 0);
        for (int k = 0; k < 30; k++) begin
            if (m_fell) begin
                init_finish = 1'b1;
                hit = 1'b1;
                @(negedge Clk);
                break;
            end
            @(negedge Clk);
        end
        n_checks++;
        if (hit !== 1'b1) begin n_errors++; $display("FAIL coincide_toggle: toggle seen got %b want 1", hit); end
        n_checks++;
        if ({init, running, fault} !== 3'b000) begin
            n_errors++; $display("FAIL coincide_idle: {init,running,fault} got %b want 000", {init, running, fault});
        end
        init_finish = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_async_reset();
        ch_mask = 4'b1111;
        init_finish = 1'b1;
        press_release(6, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (running) break;
        end
        n_checks++;
        if (running !== 1'b1) begin n_errors++; $display("FAIL areset_run: running got %b want 1", running); end
        #1 Reset = 1'b0;
        #1;
        n_checks++;
        if ({init, CS, running, fault} !== 7'b0) begin
            n_errors++; $display("FAIL areset_outputs: got %b want 0000000", {init, CS, running, fault});
        end
        #1 Reset = 1'b1;
        repeat (12) @(negedge Clk);
        n_checks++;
        if (init !== 1'b0) begin n_errors++; $display("FAIL areset_resume: init got %b want 0", init); end
        init_finish = 1'b0;
    endtask

    task automatic test_random();
        int run_left = 0;
        logic [NUM_CH-1:0] exp_cs;
        logic exp_init, exp_run, exp_fault;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                start = !start;
                run_left = $urandom_range(1, 10);
            end
            run_left--;
            init_finish = ($urandom_range(0, 11) == 0);
            ch_mask = ($urandom_range(0, 9) == 0) ? 4'b0000 : NUM_CH'($urandom);
            @(negedge Clk);
            exp_init  = (m_state == M_INIT) || (m_state == M_RUN);
            exp_run   = (m_state == M_RUN);
            exp_fault = (m_state == M_FAULT);
            exp_cs    = exp_run ? m_mask : '0;
            n_checks++;
            if ({init, CS, running, fault} !== {exp_init, exp_cs, exp_run, exp_fault}) begin
                n_errors++;
                $display("FAIL random_c%0d: {init,CS,running,fault} got %b want %b", c,
                         {init, CS, running, fault}, {exp_init, exp_cs, exp_run, exp_fault});
            end
        end
        start = 1'b0;
        init_finish = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bounce();
        test_timeout();
        test_zero_mask();
        test_abort_coincide();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
